// File: rtl/mem_wb_pipe_pkg.sv
// ============================================================================
// Module      : mem_wb_pipe_pkg
// Description : Shared types and helpers for the MEM/WB pipeline register.
// Revision    : 1.0 - initial elastic multi-slot release
// ============================================================================
`default_nettype none

package mem_wb_pipe_pkg;

  localparam int unsigned C_DATA_W = 32;
  localparam int unsigned C_ADDR_W = 5;

  // Field order fixes the bit layout that a slot register stores.
  typedef struct packed {
    logic                RegWrite;
    logic                MemtoReg;
    logic [C_ADDR_W-1:0] RDaddr;
    logic [C_DATA_W-1:0] Memdata;
    logic [C_DATA_W-1:0] ALUResult;
  } mem_wb_payload_t;

  function automatic int unsigned payload_width(input int unsigned data_w,
                                                input int unsigned addr_w);
    return 2 + addr_w + 2 * data_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_pipe_slot.sv
// ============================================================================
// Module      : pipe_slot
// Description : One elastic pipeline slot: valid bit plus payload, load enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_slot #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         flush_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Payload may follow the load even on flush; only the valid bit matters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (flush_i) begin
        r_valid <= 1'b0;
      end else if (load_i) begin
        r_valid <= valid_i;
      end
      if (load_i) begin
        r_data <= data_i;
      end
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;

endmodule

`default_nettype wire

// File: rtl/mem_wb_pipe.sv
// ============================================================================
// Module      : mem_wb_pipe
// Description : Elastic MEM/WB register chain with flush, occupancy and WB mux.
// Revision    : 1.0 - initial multi-slot release
// ============================================================================
`default_nettype none

module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = C_DATA_W,
  parameter int unsigned ADDR_W = C_ADDR_W,
  parameter int unsigned STAGES = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       RegWrite_i,
  input  logic                       MemtoReg_i,
  input  logic [ADDR_W-1:0]          RDaddr_i,
  input  logic [DATA_W-1:0]          Memdata_i,
  input  logic [DATA_W-1:0]          ALUResult_i,
  input  logic                       flush_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic                       RegWrite_o,
  output logic                       MemtoReg_o,
  output logic [ADDR_W-1:0]          RDaddr_o,
  output logic [DATA_W-1:0]          Memdata_o,
  output logic [DATA_W-1:0]          ALUResult_o,
  output logic [DATA_W-1:0]          WBdata_o,
  output logic [$clog2(STAGES+1)-1:0] count_o
);

  localparam int unsigned c_PAYLOAD_W = payload_width(DATA_W, ADDR_W);
  localparam int unsigned c_CNT_W     = $clog2(STAGES + 1);

  // Same layout as mem_wb_payload_t, sized by this instance's parameters.
  typedef struct packed {
    logic              RegWrite;
    logic              MemtoReg;
    logic [ADDR_W-1:0] RDaddr;
    logic [DATA_W-1:0] Memdata;
    logic [DATA_W-1:0] ALUResult;
  } slot_payload_t;

  slot_payload_t        w_in_payload;
  slot_payload_t        w_slot_d [STAGES];
  logic [STAGES-1:0]    w_slot_v;
  logic [STAGES-1:0]    w_load;
  logic                 w_xfer_in;
  logic                 w_xfer_out;
  logic [c_CNT_W-1:0]   r_count;

  assign w_in_payload = '{RegWrite:  RegWrite_i,
                          MemtoReg:  MemtoReg_i,
                          RDaddr:    RDaddr_i,
                          Memdata:   Memdata_i,
                          ALUResult: ALUResult_i};

  // A slot loads if it, or any slot downstream of it, is empty or drains.
  always_comb begin
    w_load = '0;
    w_load[STAGES-1] = ~w_slot_v[STAGES-1] | out_ready_i;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      w_load[k] = ~w_slot_v[k] | w_load[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    logic          w_src_v;
    slot_payload_t w_src_d;

    if (k == 0) begin : g_head
      assign w_src_v = in_valid_i;
      assign w_src_d = w_in_payload;
    end else begin : g_body
      assign w_src_v = w_slot_v[k-1];
      assign w_src_d = w_slot_d[k-1];
    end

    pipe_slot #(
      .W (c_PAYLOAD_W)
    ) u_slot (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (w_load[k]),
      .flush_i (flush_i),
      .valid_i (w_src_v),
      .data_i  (w_src_d),
      .valid_o (w_slot_v[k]),
      .data_o  (w_slot_d[k])
    );
  end

  // Held low during reset so nothing is offered as accepted.
  assign in_ready_o = w_load[0] & rst_ni;
  assign w_xfer_in  = in_valid_i & in_ready_o;
  assign w_xfer_out = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (flush_i) begin
      r_count <= '0;
    end else if (w_xfer_in && !w_xfer_out) begin
      r_count <= r_count + c_CNT_W'(1);
    end else if (!w_xfer_in && w_xfer_out) begin
      r_count <= r_count - c_CNT_W'(1);
    end
  end

  assign out_valid_o = w_slot_v[STAGES-1];
  assign RegWrite_o  = w_slot_d[STAGES-1].RegWrite & w_slot_v[STAGES-1];
  assign MemtoReg_o  = w_slot_d[STAGES-1].MemtoReg;
  assign RDaddr_o    = w_slot_d[STAGES-1].RDaddr;
  assign Memdata_o   = w_slot_d[STAGES-1].Memdata;
  assign ALUResult_o = w_slot_d[STAGES-1].ALUResult;
  assign WBdata_o    = MemtoReg_o ? Memdata_o : ALUResult_o;
  assign count_o     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_pipe.sv
// ============================================================================
// Module      : tb_mem_wb_pipe
// Description : Directed bench for mem_wb_pipe with STAGES = 1, 3 and 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, reg_write, mem_to_reg, flush, out_ready;
  logic [4:0]  rd_addr;
  logic [31:0] mem_data, alu_result;

  logic        u3_in_ready, u3_out_valid, u3_rw, u3_m2r;
  logic [4:0]  u3_rd;
  logic [31:0] u3_md, u3_alu, u3_wb;
  logic [1:0]  u3_cnt;

  logic        u4_in_ready, u4_out_valid, u4_rw, u4_m2r;
  logic [4:0]  u4_rd;
  logic [31:0] u4_md, u4_alu, u4_wb;
  logic [2:0]  u4_cnt;

  logic        u1_in_ready, u1_out_valid, u1_rw, u1_m2r;
  logic [4:0]  u1_rd;
  logic [31:0] u1_md, u1_alu, u1_wb;
  logic [0:0]  u1_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .STAGES(3)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(u3_in_ready),
    .RegWrite_i(reg_write), .MemtoReg_i(mem_to_reg), .RDaddr_i(rd_addr),
    .Memdata_i(mem_data), .ALUResult_i(alu_result), .flush_i(flush),
    .out_valid_o(u3_out_valid), .out_ready_i(out_ready), .RegWrite_o(u3_rw),
    .MemtoReg_o(u3_m2r), .RDaddr_o(u3_rd), .Memdata_o(u3_md), .ALUResult_o(u3_alu),
    .WBdata_o(u3_wb), .count_o(u3_cnt));

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .STAGES(4)) u4 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(u4_in_ready),
    .RegWrite_i(reg_write), .MemtoReg_i(mem_to_reg), .RDaddr_i(rd_addr),
    .Memdata_i(mem_data), .ALUResult_i(alu_result), .flush_i(flush),
    .out_valid_o(u4_out_valid), .out_ready_i(out_ready), .RegWrite_o(u4_rw),
    .MemtoReg_o(u4_m2r), .RDaddr_o(u4_rd), .Memdata_o(u4_md), .ALUResult_o(u4_alu),
    .WBdata_o(u4_wb), .count_o(u4_cnt));

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .STAGES(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(u1_in_ready),
    .RegWrite_i(reg_write), .MemtoReg_i(mem_to_reg), .RDaddr_i(rd_addr),
    .Memdata_i(mem_data), .ALUResult_i(alu_result), .flush_i(flush),
    .out_valid_o(u1_out_valid), .out_ready_i(out_ready), .RegWrite_o(u1_rw),
    .MemtoReg_o(u1_m2r), .RDaddr_o(u1_rd), .Memdata_o(u1_md), .ALUResult_o(u1_alu),
    .WBdata_o(u1_wb), .count_o(u1_cnt));

  typedef struct {
    logic       in_v;
    logic [4:0] rd;
    logic       ordy;
    logic       fl;
    logic       exp_rdy;
    logic       exp_ov;
    logic [4:0] exp_rd;
    logic [1:0] exp_cnt;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(input logic in_v, input logic [4:0] rd, input logic ordy,
                              input logic fl, input logic erdy, input logic eov,
                              input logic [4:0] erd, input logic [1:0] ecnt);
    vec_t v;
    v.in_v = in_v; v.rd = rd; v.ordy = ordy; v.fl = fl;
    v.exp_rdy = erdy; v.exp_ov = eov; v.exp_rd = erd; v.exp_cnt = ecnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd);
    in_valid   = v;
    rd_addr    = rd;
    alu_result = 32'(rd) << 4;
    mem_data   = ~(32'(rd) << 4);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; reg_write = 1'b1; mem_to_reg = 1'b0;
    flush = 1'b0; out_ready = 1'b0; rd_addr = '0; mem_data = '0; alu_result = '0;

    // Columns: in_v rd out_ready flush | in_ready(pre-edge) out_valid rd count (post-edge)
    vecs[0]  = mk(1, 1, 1, 0, 1, 0, 0, 1);
    vecs[1]  = mk(1, 2, 1, 0, 1, 0, 0, 2);
    vecs[2]  = mk(1, 3, 1, 0, 1, 1, 1, 3);
    vecs[3]  = mk(1, 4, 1, 0, 1, 1, 2, 3);
    vecs[4]  = mk(1, 5, 1, 0, 1, 1, 3, 3);
    vecs[5]  = mk(0, 0, 1, 0, 1, 1, 4, 2);
    vecs[6]  = mk(0, 0, 1, 0, 1, 1, 5, 1);
    vecs[7]  = mk(0, 0, 1, 0, 1, 0, 0, 0);
    vecs[8]  = mk(1, 6, 0, 0, 1, 0, 0, 1);
    vecs[9]  = mk(1, 7, 0, 0, 1, 0, 0, 2);
    vecs[10] = mk(1, 8, 0, 0, 1, 1, 6, 3);
    vecs[11] = mk(1, 9, 0, 0, 0, 1, 6, 3);
    vecs[12] = mk(1, 9, 1, 0, 1, 1, 7, 3);
    vecs[13] = mk(0, 0, 0, 0, 0, 1, 7, 3);
    vecs[14] = mk(0, 0, 1, 0, 1, 1, 8, 2);
    vecs[15] = mk(1, 10, 0, 1, 1, 0, 0, 0);
    vecs[16] = mk(0, 0, 1, 0, 1, 0, 0, 0);
    vecs[17] = mk(0, 0, 1, 0, 1, 0, 0, 0);
    vecs[18] = mk(1, 11, 0, 0, 1, 0, 0, 1);
    vecs[19] = mk(0, 0, 0, 0, 1, 0, 0, 1);
    vecs[20] = mk(0, 0, 0, 0, 1, 1, 11, 1);
    vecs[21] = mk(1, 12, 0, 0, 1, 1, 11, 2);
    vecs[22] = mk(1, 13, 0, 0, 1, 1, 11, 3);
    vecs[23] = mk(1, 14, 0, 0, 0, 1, 11, 3);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(u3_out_valid), 32'd0);
    check("rst_regwrite", 32'(u3_rw), 32'd0);
    check("rst_count", 32'(u3_cnt), 32'd0);
    check("rst_rd", 32'(u3_rd), 32'd0);
    check("rst_wbdata", u3_wb, 32'd0);
    check("rst_in_ready", 32'(u3_in_ready), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Reset mid-stream on the 4-slot pipe
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(i < 3, 5'(i + 1));
      @(posedge clk);
    end
    #1;
    check("s4_full_out_valid", 32'(u4_out_valid), 32'd1);
    check("s4_full_count", 32'(u4_cnt), 32'd3);
    check("s4_full_rd", 32'(u4_rd), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("s4_midrst_out_valid", 32'(u4_out_valid), 32'd0);
    check("s4_midrst_regwrite", 32'(u4_rw), 32'd0);
    check("s4_midrst_count", 32'(u4_cnt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 5'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("s4_post_rst_empty", 32'(u4_out_valid), 32'd0);
    end

    // Table-driven run on the 3-slot pipe
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(vecs[i].in_v, vecs[i].rd);
      out_ready = vecs[i].ordy;
      flush     = vecs[i].fl;
      #1;
      check($sformatf("v%0d_in_ready", i), 32'(u3_in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_valid", i), 32'(u3_out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("v%0d_regwrite", i), 32'(u3_rw), 32'(vecs[i].exp_ov));
      check($sformatf("v%0d_count", i), 32'(u3_cnt), 32'(vecs[i].exp_cnt));
      if (vecs[i].exp_ov) begin
        check($sformatf("v%0d_rd", i), 32'(u3_rd), 32'(vecs[i].exp_rd));
        check($sformatf("v%0d_wbdata", i), u3_wb, 32'(vecs[i].exp_rd) << 4);
      end
    end

    // Writeback mux and RegWrite gating on the single-slot pipe
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1; reg_write = 1'b1;
    mem_to_reg = 1'b1; rd_addr = 5'd3; mem_data = 32'hDEADBEEF; alu_result = 32'h1;
    @(posedge clk);
    #1;
    check("s1_out_valid", 32'(u1_out_valid), 32'd1);
    check("s1_wb_mem", u1_wb, 32'hDEADBEEF);
    check("s1_regwrite", 32'(u1_rw), 32'd1);
    check("s1_rd", 32'(u1_rd), 32'd3);
    check("s1_count", 32'(u1_cnt), 32'd1);
    @(negedge clk);
    mem_to_reg = 1'b0;
    @(posedge clk);
    #1;
    check("s1_wb_alu", u1_wb, 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("s1_bubble_out_valid", 32'(u1_out_valid), 32'd0);
    check("s1_bubble_regwrite", 32'(u1_rw), 32'd0);
    check("s1_bubble_count", 32'(u1_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
